// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit and receive chains.
package i2s_pkg;

    localparam int unsigned I2S_SAMPLE_WIDTH = 24;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with edge pulses
// derived from the synchronised level.
module i2s_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign q      = chain_q[SYNC_STAGES-1];
    assign rise_c = q & ~prev_q;
    assign fall_c = ~q & prev_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples the external bus, deserialises left/right slots
// and presents complete stereo frames on a valid/ready interface.
module i2s_rx_deserializer
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] left_data,
    output logic [SAMPLE_WIDTH-1:0] right_data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    overrun,
    output logic                    short_slot,
    input  logic                    clear_flags
);

    localparam int unsigned     CNT_W   = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_WIDTH);

    logic sclk_q, sclk_rise_c, sclk_fall_c;
    logic lr_q, lr_rise_c, lr_fall_c;
    logic sd_q, sd_rise_c, sd_fall_c;
    logic unused_edges;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (i2s_sclk),
        .q      (sclk_q),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (i2s_lrclk),
        .q      (lr_q),
        .rise_c (lr_rise_c),
        .fall_c (lr_fall_c)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (i2s_sdata),
        .q      (sd_q),
        .rise_c (sd_rise_c),
        .fall_c (sd_fall_c)
    );

    assign unused_edges = ^{sclk_q, sclk_fall_c, lr_rise_c, lr_fall_c, sd_rise_c, sd_fall_c};

    i2s_state_e              state_q, state_d;
    logic                    lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0] left_data_q, left_data_d;
    logic [SAMPLE_WIDTH-1:0] right_data_q, right_data_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    short_q, short_d;

    logic                    lr_change_c;
    logic                    cnt_full_c;
    logic [SAMPLE_WIDTH-1:0] shift_in_c;
    logic [CNT_W-1:0]        cnt_in_c;
    logic [SAMPLE_WIDTH-1:0] slot_final_c;
    logic                    slot_short_c;
    logic                    publish_c;
    logic                    short_set_c;
    logic                    overrun_set_c;

    // The bit sampled at an LR change still belongs to the slot being closed.
    assign lr_change_c  = sclk_rise_c && (lr_q != lr_prev_q);
    assign cnt_full_c   = (bit_cnt_q == CNT_MAX);
    assign shift_in_c   = cnt_full_c ? shift_q : {shift_q[SAMPLE_WIDTH-2:0], sd_q};
    assign cnt_in_c     = cnt_full_c ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
    assign slot_final_c = shift_in_c << (CNT_MAX - cnt_in_c);
    assign slot_short_c = (cnt_in_c != CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lr_prev_d     = sclk_rise_c ? lr_q : lr_prev_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        left_hold_d   = left_hold_q;
        left_data_d   = left_data_q;
        right_data_d  = right_data_q;
        valid_d       = valid_q && !ready;
        publish_c     = 1'b0;
        short_set_c   = 1'b0;
        overrun_set_c = 1'b0;

        if (!enable) begin
            state_d   = SYNC;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sclk_rise_c) begin
            case (state_q)
                SYNC: begin
                    if (lr_change_c && (lr_q == I2S_LEFT)) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                LEFT: begin
                    if (lr_change_c) begin
                        left_hold_d = slot_final_c;
                        short_set_c = slot_short_c;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                        state_d     = RIGHT;
                    end else begin
                        shift_d   = shift_in_c;
                        bit_cnt_d = cnt_in_c;
                    end
                end
                RIGHT: begin
                    if (lr_change_c) begin
                        publish_c   = 1'b1;
                        short_set_c = slot_short_c;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                        state_d     = LEFT;
                    end else begin
                        shift_d   = shift_in_c;
                        bit_cnt_d = cnt_in_c;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        // A held, unaccepted frame wins over the new one.
        if (publish_c) begin
            if (valid_q && !ready) begin
                overrun_set_c = 1'b1;
            end else begin
                left_data_d  = left_hold_q;
                right_data_d = slot_final_c;
                valid_d      = 1'b1;
            end
        end

        overrun_d = overrun_set_c | (overrun_q & ~clear_flags);
        short_d   = short_set_c | (short_q & ~clear_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_data_q  <= '0;
            right_data_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            lr_prev_q    <= lr_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            short_q      <= short_d;
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign short_slot = short_q;

endmodule
